// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic datapath:
// state encoding, counter sizing and the full-subtractor truth equations.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter wide enough to reach n without wrapping.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic logic fs_diff(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  function automatic logic fs_bout(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

endpackage

// File: rtl/fullsub.sv
// Combinational one-bit full subtractor; companion of the adder's fullsum cell.
module fullsub
  import serial_arith_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = fs_diff(A, B, bin);
  assign bout = fs_bout(A, B, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed-overflow output enabled with SERIAL_SUB_OVF_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; last result held on diff/borrow_out
// SHIFT | one operand bit per cycle through the fullsub cell
// DONE  | result valid, done pulses; start here chains the next operation
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int reglength = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [reglength-1:0] a,
  input  logic [reglength-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [reglength-1:0] diff,
  output logic                 borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int CW = cnt_width(reglength);

  state_t               state, state_nxt;
  logic [reglength-1:0] ra, rb, d_msb;
  logic [CW-1:0]        cnt;
  logic                 borrow, d, bo;
  logic                 accept, last;

  fullsub u_fullsub (
    .A    (ra[0]),
    .B    (rb[0]),
    .bin  (borrow),
    .diff (d),
    .bout (bo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (cnt == CW'(reglength - 1));
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // New bit enters at the MSB so the first (LSB) bit ends up at bit 0.
  always_comb begin
    d_msb                = '0;
    d_msb[reglength-1]   = d;
  end

  // busy/done are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      ra         <= '0;
      rb         <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      busy <= (state_nxt == SHIFT);
      done <= (state_nxt == DONE);
      if (accept) begin
        ra         <= a;
        rb         <= b;
        borrow     <= 1'b0;
        cnt        <= '0;
        diff       <= '0;
        borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf        <= 1'b0;
`endif
      end else if (state == SHIFT) begin
        diff   <= (diff >> 1) | d_msb;
        ra     <= ra >> 1;
        rb     <= rb >> 1;
        borrow <= bo;
        cnt    <= cnt + 1'b1;
        if (last) begin
          borrow_out <= bo;
`ifdef SERIAL_SUB_OVF_EN
          ovf        <= (ra[0] ^ rb[0]) & (ra[0] ^ d);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table plus hand-written multi-cycle sequences.
module tb_serial_subtractor;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] a, b;
  logic       busy, done;
  logic [2:0] diff;
  logic       borrow_out;

  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1;
  logic [0:0] diff1;
  logic       borrow_out1;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf, ovf1;
`endif

  int   passed = 0;
  int   total  = 0;
  vec_t vecs[9];

  serial_subtractor #(.reglength(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  serial_subtractor #(.reglength(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .a          (a1),
    .b          (b1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (borrow_out1)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Wait up to 8 edges for done; returns edges counted, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input int idx);
    int lat;
    @(posedge clk); #1;
    a = vecs[idx].a; b = vecs[idx].b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d busy_after_accept", idx), busy, 1);
    check($sformatf("vec%0d done_low_in_shift", idx), done, 0);
    wait_done(lat);
    check($sformatf("vec%0d latency", idx), lat, 3);
    check($sformatf("vec%0d diff", idx), diff, vecs[idx].d);
    check($sformatf("vec%0d borrow_out", idx), borrow_out, vecs[idx].bo);
`ifdef SERIAL_SUB_OVF_EN
    check($sformatf("vec%0d ovf", idx), ovf, vecs[idx].ov);
`endif
    check($sformatf("vec%0d busy_at_done", idx), busy, 0);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("vec%0d done_one_cycle", idx), done, 0);
    check($sformatf("vec%0d diff_held", idx), diff, vecs[idx].d);
  endtask

  initial begin
    int lat;
    logic seen;
    vecs[0] = '{3'd5, 3'd3, 3'd2, 1'b0, 1'b1};
    vecs[1] = '{3'd3, 3'd5, 3'd6, 1'b1, 1'b1};
    vecs[2] = '{3'd0, 3'd1, 3'd7, 1'b1, 1'b0};
    vecs[3] = '{3'd7, 3'd7, 3'd0, 1'b0, 1'b0};
    vecs[4] = '{3'd6, 3'd2, 3'd4, 1'b0, 1'b0};
    vecs[5] = '{3'd3, 3'd4, 3'd7, 1'b1, 1'b1};
    vecs[6] = '{3'd2, 3'd1, 3'd1, 1'b0, 1'b0};
    vecs[7] = '{3'd4, 3'd1, 3'd3, 1'b0, 1'b1};
    vecs[8] = '{3'd1, 3'd2, 3'd7, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset diff", diff, 0);
    check("reset borrow_out", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_op(i);

    // Start pulsed mid-SHIFT must be ignored.
    @(posedge clk); #1;
    a = 3'd5; b = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 3'd1; b = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("midshift latency", lat, 1);
    check("midshift diff", diff, 3'd2);
    check("midshift borrow_out", borrow_out, 0);
    @(posedge clk);
    @(negedge clk);
    check("midshift no_restart busy", busy, 0);
    check("midshift no_second_done", done, 0);

    // Start held through DONE chains a second operation with no idle cycle.
    @(posedge clk); #1;
    a = 3'd3; b = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    a = 3'd6; b = 3'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b2b first done", done, 1);
    check("b2b first diff", diff, 3'd6);
    check("b2b first borrow_out", borrow_out, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b no_idle busy", busy, 1);
    check("b2b done_cleared", done, 0);
    check("b2b diff_cleared", diff, 0);
    check("b2b borrow_cleared", borrow_out, 0);
    wait_done(lat);
    check("b2b second latency", lat, 3);
    check("b2b second diff", diff, 3'd4);
    check("b2b second borrow_out", borrow_out, 0);

    // Reset during the second SHIFT cycle aborts the operation.
    @(posedge clk); #1;
    a = 3'd5; b = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort diff", diff, 0);
    check("abort borrow_out", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("abort ovf", ovf, 0);
`endif
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort no_done", seen, 0);
    run_op(4);

    // reglength=1: SHIFT lasts one cycle.
    @(posedge clk); #1;
    a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    check("rl1 busy", busy1, 1);
    check("rl1 done_early", done1, 0);
    @(posedge clk);
    @(negedge clk);
    check("rl1 done", done1, 1);
    check("rl1 diff", diff1, 1);
    check("rl1 borrow_out", borrow_out1, 1);
    check("rl1 busy_at_done", busy1, 0);
    @(posedge clk);
    @(negedge clk);
    check("rl1 done_one_cycle", done1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
